// File: rtl/seq_piso_feeder.sv
`timescale 1ns/1ps
// seq_piso_feeder: parallel-in / serial-out feeder for a downstream sequence
// detector. Accepts words over valid/ready, serializes them one bit per
// enabled cycle, and uses a single holding buffer so consecutive words leave
// the serializer without a gap.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | shift register empty, dout/dout_valid/word_done held at 0
// SHIFT | shift register holds a word; dout presents its current bit

module seq_piso_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             en,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done
);

    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [WIDTH-1:0] sreg_adv;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] hold_nxt;
    logic             hold_full;
    logic             hold_full_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             xfer;
    logic             last_bit;
    logic             cur_bit;

    // Ready depends only on registered state, never on in_valid.
    assign in_ready = !hold_full;
    assign xfer     = in_valid && in_ready;
    assign last_bit = (cnt == LAST);

    // The output end of the shift register and its one-step advance.
    assign cur_bit  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign sreg_adv = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: shift register, bit counter and holding buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            sreg      <= sreg_nxt;
            cnt       <= cnt_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
        end
    end

    // Next-state, datapath updates and serial outputs.
    always_comb begin
        state_nxt     = state;
        sreg_nxt      = sreg;
        cnt_nxt       = cnt;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        dout          = 1'b0;
        dout_valid    = 1'b0;
        word_done     = 1'b0;

        case (state)
            IDLE: begin
                // Hold is always empty here, so a new word goes straight in.
                if (xfer) begin
                    sreg_nxt  = in_data;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                dout       = cur_bit;
                dout_valid = 1'b1;
                word_done  = en && last_bit;

                if (en && last_bit) begin
                    // Word boundary: refill from hold, else from the input
                    // port, else drain back to idle.
                    cnt_nxt = '0;
                    if (hold_full) begin
                        sreg_nxt      = hold;
                        hold_full_nxt = 1'b0;
                    end else if (xfer) begin
                        sreg_nxt = in_data;
                    end else begin
                        sreg_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    if (en) begin
                        sreg_nxt = sreg_adv;
                        cnt_nxt  = cnt + CW'(1);
                    end
                    // Stalled or mid-word: an accepted word waits in hold.
                    if (xfer) begin
                        hold_nxt      = in_data;
                        hold_full_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A held word only exists behind a word that is being shifted out.
    a_hold_implies_shift : assert property (
        @(posedge clk) disable iff (!rst_n) hold_full |-> (state == SHIFT));

    // word_done always marks a real data bit.
    a_done_implies_valid : assert property (
        @(posedge clk) disable iff (!rst_n) word_done |-> dout_valid);

endmodule

// File: tb/tb_seq_piso_feeder.sv
`timescale 1ns/1ps
// Bench for seq_piso_feeder: MSB-first and LSB-first instances share one
// stimulus stream; a word-queue model predicts every output each cycle.
module tb_seq_piso_feeder;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       en = 1'b0;
    logic       in_ready_m, dout_m, dv_m, wd_m;
    logic       in_ready_l, dout_l, dv_l, wd_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_piso_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .en(en), .dout(dout_m), .dout_valid(dv_m),
        .word_done(wd_m));

    seq_piso_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .en(en), .dout(dout_l), .dout_valid(dv_l),
        .word_done(wd_l));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: words awaiting output (front one is being serialized, at most
    // one more buffered) and how many bits of the front word have gone out.
    logic [7:0] wq[$];
    int         bitpos = 0;
    bit         acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq.delete();
            bitpos = 0;
        end else begin
            acc = in_valid && (wq.size() < 2);
            if (wq.size() > 0 && en) begin
                if (bitpos == W - 1) begin
                    void'(wq.pop_front());
                    bitpos = 0;
                end else begin
                    bitpos++;
                end
            end
            if (acc) wq.push_back(in_data);
        end
    end

    // Captured output streams (only enabled, valid bits) and word_done counts.
    bit log_m[$];
    bit log_l[$];
    int wdc_m = 0;
    int wdc_l = 0;
    bit ev, em, el, ewd, erdy;

    always @(negedge clk) begin
        ev   = (wq.size() > 0);
        em   = ev ? wq[0][W-1-bitpos] : 1'b0;
        el   = ev ? wq[0][bitpos] : 1'b0;
        ewd  = ev && en && (bitpos == W - 1);
        erdy = (wq.size() < 2);
        chk("msb_dout_valid", dv_m, ev);
        chk("msb_dout", dout_m, em);
        chk("msb_word_done", wd_m, ewd);
        chk("msb_in_ready", in_ready_m, erdy);
        chk("lsb_dout_valid", dv_l, ev);
        chk("lsb_dout", dout_l, el);
        chk("lsb_word_done", wd_l, ewd);
        chk("lsb_in_ready", in_ready_l, erdy);
        if (dv_m && en) log_m.push_back(dout_m);
        if (dv_l && en) log_l.push_back(dout_l);
        if (wd_m) wdc_m++;
        if (wd_l) wdc_l++;
    end

    function automatic logic [31:0] packq(input bit q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    task automatic clr();
        log_m.delete();
        log_l.delete();
        wdc_m = 0;
        wdc_l = 0;
    endtask

    // Offer one word; returns the number of edges until it was accepted.
    task automatic push_word(input logic [7:0] d, output int waited);
        bit r;
        r = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        in_data = d;
        for (int i = 0; i < 50; i++) begin
            r = in_ready_m;
            @(posedge clk);
            #1;
            waited++;
            if (r) break;
        end
        chk("push_accept_timeout", r, 1'b1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int w;
    int n1010;

    initial begin
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_m, 1'b1);
        chk("rst_dout_valid", dv_m, 1'b0);
        chk("rst_dout", dout_m, 1'b0);
        #2 rst_n = 1'b1;

        // Single word, first transfer right after reset release.
        clr();
        push_word(8'hA5, w);
        chk("t1_first_xfer_wait", w, 1);
        chk("t1_first_bit_valid", dv_m, 1'b1);
        chk("t1_first_bit", dout_m, 1'b1);
        idle(12);
        chk("t1_msb_len", log_m.size(), 8);
        chk("t1_msb_stream", packq(log_m), 32'hA5);
        chk("t1_lsb_stream", packq(log_l), 32'hA5);
        chk("t1_msb_done_cnt", wdc_m, 1);
        chk("t1_lsb_done_cnt", wdc_l, 1);
        chk("t1_idle_valid", dv_m, 1'b0);

        // Back-to-back words, no gap.
        clr();
        push_word(8'hA5, w);
        push_word(8'h0A, w);
        idle(20);
        chk("t2_msb_len", log_m.size(), 16);
        chk("t2_msb_stream", packq(log_m), 32'hA50A);
        chk("t2_lsb_stream", packq(log_l), 32'hA550);
        n1010 = 0;
        for (int i = 0; i + 3 < log_m.size(); i++)
            if ({log_m[i], log_m[i+1], log_m[i+2], log_m[i+3]} == 4'b1010) n1010++;
        chk("t2_pattern_1010_cnt", n1010, 3);
        chk("t2_msb_done_cnt", wdc_m, 2);

        // Three words offered continuously: hold-full backpressure.
        clr();
        push_word(8'h3C, w);
        push_word(8'hC3, w);
        chk("t3_ready_after_second", in_ready_m, 1'b0);
        push_word(8'h5A, w);
        chk("t3_third_wait", w, 8);
        idle(30);
        chk("t3_msb_len", log_m.size(), 24);
        chk("t3_msb_stream", packq(log_m), 32'h3CC35A);
        chk("t3_lsb_stream", packq(log_l), 32'h3CC35A);
        chk("t3_lsb_done_cnt", wdc_l, 3);

        // Stall three cycles while bit 3 is presented.
        clr();
        push_word(8'hA5, w);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b0;
        chk("t4_stall_bit_msb", dout_m, 1'b0);
        chk("t4_stall_bit_lsb", dout_l, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_stall_held_msb", dout_m, 1'b0);
        chk("t4_stall_held_valid", dv_m, 1'b1);
        en = 1'b1;
        idle(12);
        chk("t4_msb_stream", packq(log_m), 32'hA5);
        chk("t4_lsb_stream", packq(log_l), 32'hA5);
        chk("t4_msb_done_cnt", wdc_m, 1);

        // Stall on the last bit: word_done waits for en.
        clr();
        push_word(8'h0F, w);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        en = 1'b0;
        #1;
        chk("t4b_done_stalled", wd_m, 1'b0);
        chk("t4b_last_msb", dout_m, 1'b1);
        chk("t4b_last_lsb", dout_l, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        en = 1'b1;
        #1;
        chk("t4b_done_released", wd_m, 1'b1);
        idle(12);
        chk("t4b_msb_stream", packq(log_m), 32'h0F);
        chk("t4b_lsb_stream", packq(log_l), 32'hF0);
        chk("t4b_lsb_done_cnt", wdc_l, 1);

        // Reset mid-word with a word held.
        clr();
        push_word(8'hFF, w);
        push_word(8'hFF, w);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_hold_full", in_ready_m, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_dout", dout_m, 1'b0);
        chk("t5_rst_valid", dv_m, 1'b0);
        chk("t5_rst_done", wd_l, 1'b0);
        chk("t5_rst_ready_m", in_ready_m, 1'b1);
        chk("t5_rst_ready_l", in_ready_l, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        clr();
        idle(10);
        chk("t5_no_residual_m", log_m.size(), 0);
        chk("t5_no_residual_l", log_l.size(), 0);
        push_word(8'h81, w);
        idle(12);
        chk("t5_new_len", log_m.size(), 8);
        chk("t5_new_stream", packq(log_m), 32'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
